ervp_platform_ctrl_regfile_mc: RTL and testbench
================================================

// Module: ervp_platform_ctrl_regfile_mc
// PURPOSE
//  APB register file for the platform controller, generalised to NUM_CORE cores.
//  Provides boot mode/status, app address, per-core hold control and a core-select snapshot engine.
//  The snapshot engine requests a PC/INST capture from the selected core over a req/ack handshake, with a timeout.
//  Sits between the APB bus and the core cluster / boot logic.
// PARAMETERS
//  NUM_CORE        4            cores served (1..16); CORE_SEL width = max(1,clog2(NUM_CORE))
//  BW_ADDR         12           APB address width; offset = paddr[5:2], paddr[BW_ADDR-1:6] and [1:0] must be 0
//  APP_ADDR_RST    32'h8000_0000  reset value of APP_ADDR
//  HOLD_RST        {NUM_CORE{1'b1}} & ~1  reset value of CORE_HOLD (core0 runs)
//  SNAP_TIMEOUT    255          cycles in REQ before abort (8-bit counter, 1..255)
// PORTS
//  clk            in   1              clock
//  rstnn          in   1              async active-low reset
//  psel           in   1              APB select
//  penable        in   1              APB enable
//  paddr          in   BW_ADDR        APB address
//  pwrite         in   1              APB write
//  pwdata         in   32             APB write data
//  prdata         out  32             APB read data (combinational, 0 when not a valid read)
//  pready         out  1              tied 1
//  pslverr        out  1              error on access phase
//  boot_mode      in   4              boot mode straps
//  initialized    in   1              platform initialised
//  proc_status    in   NUM_CORE       per-core running flags
//  app_addr       out  32             APP_ADDR register
//  core_hold      out  NUM_CORE       CORE_HOLD register
//  snap_req       out  NUM_CORE       one-hot capture request
//  snap_ack       in   NUM_CORE       per-core capture ack
//  core_pc_list   in   32*NUM_CORE    core PCs, core i at [32*i+:32]
//  core_inst_list in   32*NUM_CORE    core instructions, same packing
// BEHAVIOUR
//  Access = psel&penable; wr/rd per pwrite; side effects only in access phase; all state async-reset.
//  Map (byte offset): 00 BOOT_MODE ro | 04 INITIALIZED ro | 08 APP_ADDR rw | 0C CORE_HOLD rw
//   10 CORE_SEL rw | 14 SNAP_CTRL | 18 SNAP_PC ro | 1C SNAP_INST ro | 20 PROC_STATUS ro | 24 BOOT_STATUS rw32
//  Read-only regs: writes ignored, pslverr=0. Unused bits read 0, ignore writes.
//  pslverr=1: unmapped offset, nonzero high/low addr bits, CORE_SEL write >= NUM_CORE,
//   CORE_SEL or SNAP_CTRL start write while BUSY. An erroring write changes no state.
//  Reset: app_addr=APP_ADDR_RST, core_hold=HOLD_RST, CORE_SEL=0, BOOT_STATUS=0,
//   SNAP_PC/INST=0, status flags=0, FSM=IDLE, snap_req=0.
//  SNAP_CTRL read = {29'b0, busy, timeout, done}; write with pwdata[0]=1 in IDLE starts a capture.
//   A start write clears done and timeout; writes with bit0=0 do nothing.
//  FSM IDLE->REQ on start: latch sel_q=CORE_SEL, cnt=0, busy=1. The cycle after the start write, snap_req[sel_q]=1.
//  REQ: snap_req held until snap_ack[sel_q]=1 (acks of other cores ignored). On that edge, capture
//   core_pc_list/inst_list slice sel_q into SNAP_PC/INST, set done=1, go IDLE; snap_req drops the next cycle.
//  REQ with no ack: cnt++ each cycle; when cnt==SNAP_TIMEOUT-1 with no ack, set timeout=1, go IDLE.
//   SNAP_PC/INST keep their old values. Ack and timeout on the same cycle: ack wins.
//  CORE_SEL changes never affect an in-flight capture (sel_q is used).
//  core_hold bits apply 1 cycle after the write; a held core's request still runs and may time out.
//  Async reset mid-REQ: drops snap_req immediately and returns to IDLE.
// TESTING
//  Reset -> read 08=8000_0000, 0C=0000_000E, 14=0, and snap_req=0.
//  Write 10=2, write 14=1; ack[2] after 3 cycles with pc2=1234_5678 -> snap_req=4'b0100 for 3 cycles; 14 reads 1; 18=1234_5678.
//  Start capture on core1 with no ack -> snap_req held 255 cycles; 14 reads 2; 18/1C unchanged.
//  While BUSY, write 10=3 and write 14=1 -> pslverr=1 both, CORE_SEL unchanged, capture completes on original core.
//  Write 10=4 (NUM_CORE=4), read 0x28, access paddr=0x41 -> pslverr=1, no state change.
//  Assert rstnn low while in REQ -> snap_req=0 at once; after release, 14 reads 0 and FSM accepts a new start.

Source files
------------

// File: rtl/ervp_platform_ctrl_regfile_mc.sv
// APB register file for the platform controller serving NUM_CORE cores:
// boot info, app address, per-core hold and a PC/INST snapshot engine with timeout.
module ervp_platform_ctrl_regfile_mc #(
  parameter int                  NUM_CORE     = 4,
  parameter int                  BW_ADDR      = 12,
  parameter logic [31:0]         APP_ADDR_RST = 32'h8000_0000,
  parameter logic [NUM_CORE-1:0] HOLD_RST     = ~NUM_CORE'(1),
  parameter int                  SNAP_TIMEOUT = 255,
  localparam int                 SW           = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [BW_ADDR-1:0]    paddr,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [3:0]            boot_mode,
  input  logic                  initialized,
  input  logic [NUM_CORE-1:0]   proc_status,
  output logic [31:0]           app_addr,
  output logic [NUM_CORE-1:0]   core_hold,
  output logic [NUM_CORE-1:0]   snap_req,
  input  logic [NUM_CORE-1:0]   snap_ack,
  input  logic [32*NUM_CORE-1:0] core_pc_list,
  input  logic [32*NUM_CORE-1:0] core_inst_list
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t      state, state_nxt;
  logic        access, wr, rd;
  logic [3:0]  offset;
  logic        addr_ok, mapped, err;
  logic        busy, start, ack_hit, cnt_end;
  logic [SW-1:0] core_sel, sel_q;
  logic [31:0] boot_status, snap_pc, snap_inst;
  logic        done, timeout;
  logic [7:0]  cnt;

  assign access  = psel & penable;
  assign wr      = access & pwrite;
  assign rd      = access & ~pwrite;
  assign offset  = paddr[5:2];
  assign addr_ok = (paddr[BW_ADDR-1:6] == '0) && (paddr[1:0] == 2'b00);
  assign mapped  = (offset <= 4'd9);
  assign busy    = (state == S_REQ);

  // CORE_SEL and a capture start are both refused while a capture is in flight.
  assign err = ~addr_ok | ~mapped
             | (pwrite && offset == 4'd4 && (busy || pwdata >= 32'(NUM_CORE)))
             | (pwrite && offset == 4'd5 && pwdata[0] && busy);

  assign pready  = 1'b1;
  assign pslverr = access & err;
  assign start   = wr && !err && offset == 4'd5 && pwdata[0];
  assign ack_hit = snap_ack[sel_q];
  assign cnt_end = (cnt == 8'(SNAP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ:  if (ack_hit || cnt_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    snap_req = '0;
    if (busy) snap_req[sel_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      app_addr    <= APP_ADDR_RST;
      core_hold   <= HOLD_RST;
      core_sel    <= '0;
      boot_status <= '0;
      sel_q       <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      snap_pc     <= '0;
      snap_inst   <= '0;
    end else begin
      if (wr && !err) begin
        case (offset)
          4'd2: app_addr    <= pwdata;
          4'd3: core_hold   <= pwdata[NUM_CORE-1:0];
          4'd4: core_sel    <= pwdata[SW-1:0];
          4'd9: boot_status <= pwdata;
          default: ;
        endcase
      end
      if (start) begin
        sel_q   <= core_sel;
        cnt     <= '0;
        done    <= 1'b0;
        timeout <= 1'b0;
      end
      // An ack on the final counted cycle still wins over the timeout.
      if (busy) begin
        if (ack_hit) begin
          snap_pc   <= core_pc_list[32*sel_q +: 32];
          snap_inst <= core_inst_list[32*sel_q +: 32];
          done      <= 1'b1;
        end else if (cnt_end) begin
          timeout <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (rd && !err) begin
      case (offset)
        4'd0: prdata[3:0]          = boot_mode;
        4'd1: prdata[0]            = initialized;
        4'd2: prdata               = app_addr;
        4'd3: prdata[NUM_CORE-1:0] = core_hold;
        4'd4: prdata[SW-1:0]       = core_sel;
        4'd5: prdata[2:0]          = {busy, timeout, done};
        4'd6: prdata               = snap_pc;
        4'd7: prdata               = snap_inst;
        4'd8: prdata[NUM_CORE-1:0] = proc_status;
        4'd9: prdata               = boot_status;
        default: prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ervp_platform_ctrl_regfile_mc.sv
// Scoreboard bench: APB responses and snap_req bursts are predicted by a register-level
// model, queued at issue time, and checked by independent monitors.
module tb_ervp_platform_ctrl_regfile_mc;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic [3:0] boot_mode = 4'h5;
  logic initialized = 1'b1;
  logic [NC-1:0] proc_status = 4'b1010;
  logic [31:0] app_addr;
  logic [NC-1:0] core_hold, snap_req;
  logic [NC-1:0] snap_ack = '0;
  logic [32*NC-1:0] core_pc_list = '0, core_inst_list = '0;

  always #5 clk = ~clk;

  ervp_platform_ctrl_regfile_mc #(
    .NUM_CORE(NC), .BW_ADDR(12), .APP_ADDR_RST(32'h8000_0000),
    .HOLD_RST(4'b1110), .SNAP_TIMEOUT(255)
  ) dut (
    .clk(clk), .rstnn(rstnn), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .boot_mode(boot_mode), .initialized(initialized),
    .proc_status(proc_status), .app_addr(app_addr), .core_hold(core_hold),
    .snap_req(snap_req), .snap_ack(snap_ack), .core_pc_list(core_pc_list),
    .core_inst_list(core_inst_list)
  );

  int checks = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_app, m_boot, m_pc, m_inst;
  logic [NC-1:0] m_hold;
  int unsigned m_sel;
  bit m_done, m_to, m_busy;

  task automatic model_reset();
    m_app = 32'h8000_0000; m_hold = 4'b1110; m_sel = 0; m_boot = '0;
    m_pc = '0; m_inst = '0; m_done = 0; m_to = 0; m_busy = 0;
  endtask

  typedef struct {
    logic [31:0] data;
    bit          err;
    logic [31:0] app;
    logic [NC-1:0] hold;
    logic [11:0] addr;
  } apb_exp_t;
  apb_exp_t apb_q[$];

  typedef struct {
    logic [NC-1:0] onehot;
    int            cycles;
  } snap_exp_t;
  snap_exp_t snap_q[$];

  task automatic model_access(input bit w, input logic [11:0] a, input logic [31:0] d,
                              output logic [31:0] rdata, output bit bad);
    int unsigned o;
    o = int'(a[5:2]);
    bad = (a[11:6] != 0) || (a[1:0] != 0) || (o > 9);
    if (w && o == 4 && (m_busy || d >= NC)) bad = 1;
    if (w && o == 5 && d[0] && m_busy) bad = 1;
    rdata = '0;
    if (!w && !bad) begin
      case (o)
        0: rdata = {28'd0, boot_mode};
        1: rdata = {31'd0, initialized};
        2: rdata = m_app;
        3: rdata = {28'd0, m_hold};
        4: rdata = m_sel;
        5: rdata = {29'd0, m_busy, m_to, m_done};
        6: rdata = m_pc;
        7: rdata = m_inst;
        8: rdata = {28'd0, proc_status};
        9: rdata = m_boot;
        default: rdata = '0;
      endcase
    end
    if (w && !bad) begin
      case (o)
        2: m_app = d;
        3: m_hold = d[NC-1:0];
        4: m_sel = d;
        5: if (d[0]) begin m_done = 0; m_to = 0; m_busy = 1; end
        9: m_boot = d;
        default: ;
      endcase
    end
  endtask

  // Called #1 after a posedge; returns #1 after the access-phase edge.
  task automatic apb(input bit w, input logic [11:0] a, input logic [31:0] d);
    apb_exp_t e;
    e.app = m_app; e.hold = m_hold; e.addr = a;
    model_access(w, a, d, e.data, e.err);
    apb_q.push_back(e);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  always @(negedge clk) begin
    if (psel && penable) begin
      if (apb_q.size() == 0) begin
        check("apb_unexpected", 32'd1, 32'd0);
      end else begin
        apb_exp_t e;
        e = apb_q.pop_front();
        check($sformatf("prdata@%h", e.addr), prdata, e.data);
        check($sformatf("pslverr@%h", e.addr), {31'd0, pslverr}, {31'd0, e.err});
        check("app_addr", app_addr, e.app);
        check("core_hold", {28'd0, core_hold}, {28'd0, e.hold});
      end
    end
  end

  int run_len = 0;
  logic [NC-1:0] run_or = '0;
  always @(negedge clk) begin
    if (snap_req != '0) begin
      run_len++;
      run_or |= snap_req;
    end else if (run_len != 0) begin
      if (snap_q.size() == 0) begin
        check("snap_unexpected", 32'd1, 32'd0);
      end else begin
        snap_exp_t s;
        s = snap_q.pop_front();
        check("snap_req_core", {28'd0, run_or}, {28'd0, s.onehot});
        check("snap_req_cycles", run_len, s.cycles);
      end
      run_len = 0;
      run_or = '0;
    end
  end

  function automatic logic [NC-1:0] others(input int unsigned core);
    logic [NC-1:0] r;
    r = NC'($urandom);
    r[core] = 1'b0;
    return r;
  endfunction

  // Ack arrives so that it is sampled on the delay-th edge after the start write;
  // delay > 255 means the core never answers.
  task automatic ack_after(input int unsigned core, input int unsigned delay);
    snap_exp_t s;
    s.onehot = '0; s.onehot[core] = 1'b1;
    if (delay <= 255) begin
      s.cycles = delay;
      snap_q.push_back(s);
      repeat (delay - 1) begin snap_ack = others(core); @(posedge clk); #1; end
      snap_ack = others(core); snap_ack[core] = 1'b1;
      @(posedge clk); #1 snap_ack = '0;
      m_pc = core_pc_list[32*core +: 32];
      m_inst = core_inst_list[32*core +: 32];
      m_done = 1; m_busy = 0;
    end else begin
      s.cycles = 255;
      snap_q.push_back(s);
      repeat (258) begin snap_ack = others(core); @(posedge clk); #1; end
      snap_ack = '0;
      m_to = 1; m_busy = 0;
    end
  endtask

  task automatic capture(input int unsigned core, input int unsigned delay);
    apb(1, 12'h010, core);
    apb(1, 12'h014, 32'h1);
    ack_after(core, delay);
  endtask

  task automatic randomize_inputs();
    boot_mode = 4'($urandom); initialized = 1'($urandom); proc_status = NC'($urandom);
    for (int i = 0; i < NC; i++) begin
      core_pc_list[32*i +: 32] = $urandom;
      core_inst_list[32*i +: 32] = $urandom;
    end
  endtask

  initial begin
    model_reset();
    randomize_inputs();
    repeat (3) @(posedge clk);
    #1 rstnn = 1;
    check("snap_req_reset", {28'd0, snap_req}, 32'd0);
    @(posedge clk); #1;
    apb(0, 12'h008, 0);
    apb(0, 12'h00C, 0);
    apb(0, 12'h014, 0);

    // Capture on core 2, ack after 3 cycles
    core_pc_list[64 +: 32] = 32'h1234_5678;
    capture(2, 3);
    apb(0, 12'h014, 0);
    apb(0, 12'h018, 0);
    apb(0, 12'h01C, 0);

    // Timeout on core 1
    capture(1, 999);
    apb(0, 12'h014, 0);
    apb(0, 12'h018, 0);
    apb(0, 12'h01C, 0);

    // Writes refused while busy; capture finishes on the original core
    apb(1, 12'h010, 2);
    apb(1, 12'h014, 1);
    fork
      ack_after(2, 20);
      begin
        apb(1, 12'h010, 3);
        apb(1, 12'h014, 1);
        apb(0, 12'h010, 0);
        apb(0, 12'h014, 0);
      end
    join
    apb(0, 12'h014, 0);
    apb(0, 12'h018, 0);
    apb(0, 12'h010, 0);

    // Address and value errors
    apb(1, 12'h010, 4);
    apb(0, 12'h028, 0);
    apb(0, 12'h041, 0);
    apb(1, 12'h041, 32'hDEAD_BEEF);
    apb(1, 12'h048, 32'hDEAD_BEEF);
    apb(1, 12'h00A, 32'h1111_1111);
    apb(0, 12'h008, 0);
    apb(0, 12'h010, 0);

    // Async reset mid-request
    apb(1, 12'h010, 1);
    apb(1, 12'h014, 1);
    begin
      snap_exp_t s;
      s.onehot = 4'b0010; s.cycles = 10;
      snap_q.push_back(s);
    end
    repeat (10) begin @(posedge clk); #1; end
    rstnn = 0;
    #1 check("snap_req_async_rst", {28'd0, snap_req}, 32'd0);
    model_reset();
    @(posedge clk); #1 rstnn = 1;
    @(posedge clk); #1;
    apb(0, 12'h014, 0);
    apb(0, 12'h008, 0);
    apb(0, 12'h00C, 0);
    apb(0, 12'h010, 0);
    capture(3, 7);
    apb(0, 12'h014, 0);
    apb(0, 12'h01C, 0);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          logic [11:0] a;
          a = 12'($urandom_range(0, 11) << 2);
          if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
          if ($urandom_range(0, 7) == 0) a[6] = 1'b1;
          apb(0, a, 0);
        end
        2: apb(1, 12'h008, $urandom);
        3: apb(1, 12'h00C, $urandom);
        4: apb(1, 12'h024, $urandom);
        5: apb(1, 12'h010, $urandom_range(0, 5));
        6: begin
          int unsigned ro[5] = '{0, 1, 6, 7, 8};
          apb(1, 12'(ro[$urandom_range(0, 4)] << 2), $urandom);
        end
        7: apb(1, 12'h014, $urandom & 32'hFFFF_FFFE);
        8: capture($urandom_range(0, NC - 1),
                   (it % 60 == 0) ? 300 : $urandom_range(1, 30));
        default: randomize_inputs();
      endcase
    end
    apb(0, 12'h014, 0);
    apb(0, 12'h018, 0);
    apb(0, 12'h01C, 0);
    apb(0, 12'h024, 0);

    repeat (5) @(posedge clk);
    check("apb_q_drained", apb_q.size(), 32'd0);
    check("snap_q_drained", snap_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
